jump_target_gen: RTL and testbench

- Parametrised successor to the fixed 2-to-8-bit jump-offset sign extender.
- Accepts a narrow immediate field plus the current PC and produces the registered absolute jump target.
- Immediate is sign- or zero-extended and optionally scaled by a left shift, then added to the PC.
- Two-stage valid/ready pipeline between decode and the PC-update logic; fetch backpressure and branch flush are supported.

---
 rtl/jump_pkg.sv | 21 ++
 rtl/imm_extend.sv | 23 ++
 rtl/jump_target_gen.sv | 107 ++++++++++
 tb/tb_jump_target_gen.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/jump_pkg.sv
// Shared jump/branch immediate definitions: default widths, extension modes
// and a fixed-width extension helper reused by the branch unit.
package jump_pkg;

   localparam int unsigned ADDR_W = 8;
   localparam int unsigned JIMM_W = 2;

   localparam logic EXT_SIGN = 1'b0;
   localparam logic EXT_ZERO = 1'b1;

   function automatic logic [ADDR_W-1:0] ext_imm(input logic [JIMM_W-1:0] imm,
                                                 input logic              mode);
      logic [ADDR_W-1:0] res;
      res = ADDR_W'(imm);
      if (mode == EXT_SIGN) begin
         res = {{(ADDR_W-JIMM_W){imm[JIMM_W-1]}}, imm};
      end
      return res;
   endfunction

endpackage

// File: rtl/imm_extend.sv
// Combinational immediate extender: sign- or zero-extends an IMM_W field
// to OUT_W bits.
module imm_extend
   import jump_pkg::*;
#(
   parameter int unsigned IMM_W = JIMM_W,
   parameter int unsigned OUT_W = ADDR_W
) (
   input  logic [IMM_W-1:0] imm,
   input  logic             zero_ext,
   output logic [OUT_W-1:0] ext_c
);

   generate
      if (IMM_W == OUT_W) begin : g_full
         assign ext_c = imm;
      end else begin : g_ext
         assign ext_c = (zero_ext == EXT_ZERO) ? {{(OUT_W-IMM_W){1'b0}}, imm}
                                               : {{(OUT_W-IMM_W){imm[IMM_W-1]}}, imm};
      end
   endgenerate

endmodule

// File: rtl/jump_target_gen.sv
// Two-stage valid/ready jump target generator: stage 1 extends the immediate,
// stage 2 registers PC + (ext << SHIFT). JTG_OVF_EN adds the Overflow output.
module jump_target_gen
   import jump_pkg::*;
#(
   parameter int unsigned IMM_W = JIMM_W,
   parameter int unsigned OUT_W = ADDR_W,
   parameter int unsigned SHIFT = 0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             Flush,
   input  logic             InValid,
   output logic             InReady,
   input  logic [IMM_W-1:0] Imm,
   input  logic [OUT_W-1:0] PC,
   input  logic             ZeroExt,
   output logic             OutValid,
   input  logic             OutReady,
   output logic [OUT_W-1:0] Target
`ifdef JTG_OVF_EN
   ,
   output logic             Overflow
`endif
);

   logic             s1_valid;
   logic [OUT_W-1:0] s1_pc;
   logic [OUT_W-1:0] s1_ext;
   logic             s2_valid;
   logic [OUT_W-1:0] ext_c;
   logic [OUT_W-1:0] target_c;
   logic             s2_free;
   logic             s1_free;
   logic             accept;

   imm_extend #(
      .IMM_W (IMM_W),
      .OUT_W (OUT_W)
   ) u_imm_extend (
      .imm      (Imm),
      .zero_ext (ZeroExt),
      .ext_c    (ext_c)
   );

   assign s2_free  = !s2_valid || OutReady;
   assign s1_free  = !s1_valid || s2_free;
   assign InReady  = s1_free;
   assign accept   = InValid && s1_free && !Flush;
   assign OutValid = s2_valid;

   // Bits shifted past OUT_W drop out here; the add wraps silently.
   assign target_c = s1_pc + OUT_W'(s1_ext << SHIFT);

`ifdef JTG_OVF_EN
   localparam int unsigned WIDE_W = OUT_W + SHIFT + 2;

   logic              s1_neg;
   logic              neg_c;
   logic [WIDE_W-1:0] off_w;
   logic [WIDE_W-1:0] sum_w;
   logic              ovf_c;

   assign neg_c = (ZeroExt == EXT_SIGN) && Imm[IMM_W-1];
   assign off_w = {{(SHIFT+2){s1_neg}}, s1_ext} << SHIFT;
   assign sum_w = {{(SHIFT+2){1'b0}}, s1_pc} + off_w;
   // Wrapped the address space, or the shift lost bits that were not sign fill.
   assign ovf_c = (sum_w[WIDE_W-1:OUT_W] != '0) ||
                  (off_w[WIDE_W-1:OUT_W] != {(SHIFT+2){s1_neg}});
`endif

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         s1_valid <= 1'b0;
         s1_pc    <= '0;
         s1_ext   <= '0;
         s2_valid <= 1'b0;
         Target   <= '0;
`ifdef JTG_OVF_EN
         s1_neg   <= 1'b0;
         Overflow <= 1'b0;
`endif
      end else if (Flush) begin
         s1_valid <= 1'b0;
         s2_valid <= 1'b0;
      end else begin
         s1_valid <= accept || (s1_valid && !s2_free);
         if (accept) begin
            s1_pc  <= PC;
            s1_ext <= ext_c;
`ifdef JTG_OVF_EN
            s1_neg <= neg_c;
`endif
         end
         if (s2_free) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
               Target <= target_c;
`ifdef JTG_OVF_EN
               Overflow <= ovf_c;
`endif
            end
         end
      end
   end

endmodule

// File: tb/tb_jump_target_gen.sv
// Scoreboard bench for jump_target_gen: one SHIFT=0 and one SHIFT=2 instance
// share stimulus; expected targets are queued on accept and checked on output.
module tb_jump_target_gen;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       Flush;
   logic       InValid;
   logic       InReady, in_ready2;
   logic [1:0] Imm;
   logic [7:0] PC;
   logic       ZeroExt;
   logic       OutValid, out_valid2;
   logic       OutReady;
   logic [7:0] Target, target2;
`ifdef JTG_OVF_EN
   logic       Overflow, overflow2;
`endif

   typedef struct {
      logic [7:0] t0;
      logic [7:0] t2;
      logic       o0;
      logic       o2;
   } exp_t;

   exp_t q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   logic prev_stall = 1'b0;
   logic [7:0] prev_target = '0;

   always #5 clk = ~clk;

   jump_target_gen #(.IMM_W(2), .OUT_W(8), .SHIFT(0)) dut (
      .clk(clk), .reset_n(reset_n), .Flush(Flush), .InValid(InValid), .InReady(InReady),
      .Imm(Imm), .PC(PC), .ZeroExt(ZeroExt), .OutValid(OutValid), .OutReady(OutReady),
      .Target(Target)
`ifdef JTG_OVF_EN
      , .Overflow(Overflow)
`endif
   );

   jump_target_gen #(.IMM_W(2), .OUT_W(8), .SHIFT(2)) dut2 (
      .clk(clk), .reset_n(reset_n), .Flush(Flush), .InValid(InValid), .InReady(in_ready2),
      .Imm(Imm), .PC(PC), .ZeroExt(ZeroExt), .OutValid(out_valid2), .OutReady(OutReady),
      .Target(target2)
`ifdef JTG_OVF_EN
      , .Overflow(overflow2)
`endif
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference: integer arithmetic on the extended immediate; bit 8 = out of range.
   function automatic logic [8:0] model(input logic [1:0] imm, input logic [7:0] pc,
                                        input logic z, input int sh);
      int e;
      int v;
      e = z ? int'(imm) : (imm[1] ? int'(imm) - 4 : int'(imm));
      v = int'(pc) + e * (1 << sh);
      return {(v < 0 || v > 255), 8'(v)};
   endfunction

   always @(negedge clk) begin
      if (!reset_n) begin
         q.delete();
         prev_stall = 1'b0;
      end else begin
         check("in_ready", 32'(InReady), 32'(!(q.size() == 2 && !OutReady)));
         if (prev_stall) check("hold_target", 32'(Target), 32'(prev_target));
         if (OutValid && q.size() == 0) check("spurious_valid", 32'(OutValid), 32'(0));
         if (OutValid && OutReady && q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            check("target_s0", 32'(Target), 32'(e.t0));
            check("target_s2", 32'(target2), 32'(e.t2));
`ifdef JTG_OVF_EN
            check("ovf_s0", 32'(Overflow), 32'(e.o0));
            check("ovf_s2", 32'(overflow2), 32'(e.o2));
`endif
         end
         if (Flush) begin
            q.delete();
         end else if (InValid && InReady) begin
            exp_t e;
            logic [8:0] m0, m2;
            m0 = model(Imm, PC, ZeroExt, 0);
            m2 = model(Imm, PC, ZeroExt, 2);
            e.t0 = m0[7:0]; e.o0 = m0[8];
            e.t2 = m2[7:0]; e.o2 = m2[8];
            q.push_back(e);
         end
         prev_stall  = OutValid && !OutReady;
         prev_target = Target;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [1:0] imm, input logic [7:0] pc, input logic z);
      logic acc;
      acc = 1'b0;
      InValid = 1'b1; Imm = imm; PC = pc; ZeroExt = z;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (InReady) begin
            acc = 1'b1;
            break;
         end
      end
      step();
      InValid = 1'b0;
      if (!acc) check("send_timeout", 32'(acc), 32'(1));
   endtask

   task automatic drain();
      logic done;
      done = 1'b0;
      OutReady = 1'b1;
      InValid  = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (q.size() == 0) begin
            done = 1'b1;
            break;
         end
      end
      if (!done) check("drain_timeout", 32'(q.size()), 32'(0));
      step();
   endtask

   initial begin
      reset_n = 1'b0; Flush = 1'b0; InValid = 1'b0; Imm = '0; PC = '0;
      ZeroExt = 1'b0; OutReady = 1'b1;
      step(); step();
      reset_n = 1'b1;
      @(negedge clk);
      check("rst_out_valid", 32'(OutValid), 32'(0));
      check("rst_target", 32'(Target), 32'(0));
      check("rst_target_s2", 32'(target2), 32'(0));
      check("rst_in_ready", 32'(InReady), 32'(1));
`ifdef JTG_OVF_EN
      check("rst_ovf", 32'(Overflow), 32'(0));
`endif
      step();

      // Latency: accept edge N, valid after N+1.
      send(2'b11, 8'h10, 1'b0);
      @(negedge clk);
      check("lat_edge_n", 32'(OutValid), 32'(0));
      @(negedge clk);
      check("lat_edge_n1", 32'(OutValid), 32'(1));
      check("t_sign_10_m1", 32'(Target), 32'(8'h0F));
      check("t_sign_10_m1_s2", 32'(target2), 32'(8'h0C));
      drain();

      send(2'b11, 8'h10, 1'b1);
      @(negedge clk);
      @(negedge clk);
      check("t_zero_13", 32'(Target), 32'(8'h13));
      check("t_zero_1c_s2", 32'(target2), 32'(8'h1C));
      drain();

      // Wrap boundaries, back to back.
      send(2'b10, 8'h00, 1'b0);
      send(2'b01, 8'hFF, 1'b0);
      send(2'b11, 8'h00, 1'b0);
      send(2'b11, 8'hFF, 1'b1);
      drain();

      // Backpressure: two accepted, third stalls, then all three in order.
      OutReady = 1'b0;
      send(2'b01, 8'h20, 1'b0);
      send(2'b10, 8'h30, 1'b0);
      InValid = 1'b1; Imm = 2'b11; PC = 8'h40; ZeroExt = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("bp_in_ready", 32'(InReady), 32'(0));
         check("bp_out_valid", 32'(OutValid), 32'(1));
      end
      step();
      OutReady = 1'b1;
      send(2'b11, 8'h40, 1'b1);
      drain();

      // Flush with both stages full; flushed-cycle input must never appear.
      OutReady = 1'b0;
      send(2'b01, 8'h50, 1'b0);
      send(2'b01, 8'h60, 1'b0);
      OutReady = 1'b1; Flush = 1'b1;
      InValid = 1'b1; Imm = 2'b10; PC = 8'h70; ZeroExt = 1'b0;
      @(negedge clk);
      check("flush_in_ready", 32'(InReady), 32'(1));
      step();
      Flush = 1'b0; InValid = 1'b0;
      @(negedge clk);
      check("flush_out_valid", 32'(OutValid), 32'(0));
      step();
      send(2'b01, 8'h80, 1'b1);
      drain();

      // Reset mid-stream.
      send(2'b01, 8'h90, 1'b0);
      InValid = 1'b1; Imm = 2'b11; PC = 8'hA0; reset_n = 1'b0;
      step();
      reset_n = 1'b1; InValid = 1'b0;
      @(negedge clk);
      check("mid_rst_out_valid", 32'(OutValid), 32'(0));
      check("mid_rst_target", 32'(Target), 32'(0));
      check("mid_rst_in_ready", 32'(InReady), 32'(1));
      step();
      @(negedge clk);
      check("mid_rst_quiet", 32'(OutValid), 32'(0));
      step();
      send(2'b10, 8'h33, 1'b0);
      @(negedge clk);
      @(negedge clk);
      check("post_rst_valid", 32'(OutValid), 32'(1));
      check("post_rst_target", 32'(Target), 32'(8'h31));
      drain();

      // Random traffic with random backpressure and occasional flush.
      for (int i = 0; i < 200; i++) begin
         InValid  = 1'($urandom_range(0, 1));
         OutReady = 1'($urandom_range(0, 1));
         Flush    = ($urandom_range(0, 15) == 0);
         Imm      = 2'($urandom);
         PC       = 8'($urandom);
         ZeroExt  = 1'($urandom);
         step();
      end
      Flush = 1'b0;
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
